// File: rtl/chess_clock_core_n.sv
// N-player BCD mm:ss countdown core for the chess clock. It supports preset
// load, a Fischer increment on handover, per-player flag-fall and pause.
module chess_clock_core_n #(
    parameter int          N_PLAYERS = 2,
    parameter int          TICK_DIV  = 50000000,
    parameter logic [7:0]  RESET_MIN = 8'h05,
    parameter logic [7:0]  RESET_SEC = 8'h00,
    localparam int         PW        = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      CE,
    input  logic                      SELECT,
    input  logic                      STOP,
    input  logic                      Set_Impulse,
    input  logic [7:0]                LOAD_MIN,
    input  logic [7:0]                LOAD_SEC,
    input  logic [7:0]                INC_SEC,
    output logic [16*N_PLAYERS-1:0]   TIME_BCD,
    output logic [PW-1:0]             ACTIVE,
    output logic [N_PLAYERS-1:0]      FLAG,
    output logic                      RUNNING,
    output logic                      LOAD_ERR
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FLAGGED} state_t;

    state_t                       state_q, state_d;
    logic [N_PLAYERS-1:0][15:0]   time_q, time_d;
    logic [PW-1:0]                active_q, active_d;
    logic [N_PLAYERS-1:0]         flag_q, flag_d;
    logic [CW-1:0]                presc_q, presc_d;
    logic                         load_err_q, load_err_d;
    logic                         select_hist, load_hist;

    logic        sel_e, ld_e, tick, load_ok, inc_ok;
    logic [7:0]  inc_val;
    logic [15:0] cur_time, dec_time, work_time;
    logic [PW-1:0] next_active;

    // One-second BCD decrement; only used on a non-zero time.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // Adds increment seconds with carry into minutes, saturating at 99:59.
    function automatic logic [15:0] bcd_add_sec(input logic [15:0] t, input logic [7:0] inc);
        int s;
        int m;
        s = int'(t[7:4]) * 10 + int'(t[3:0]) + int'(inc[7:4]) * 10 + int'(inc[3:0]);
        m = int'(t[15:12]) * 10 + int'(t[11:8]);
        if (s >= 60) begin
            s = s - 60;
            m = m + 1;
        end
        if (m > 99) begin
            return 16'h9959;
        end
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    assign sel_e   = SELECT & ~select_hist;
    assign ld_e    = Set_Impulse & ~load_hist;
    assign tick    = (state_q == RUN) && (presc_q == CW'(TICK_DIV - 1));
    assign load_ok = (LOAD_MIN[7:4] <= 4'd9) && (LOAD_MIN[3:0] <= 4'd9) &&
                     (LOAD_SEC[7:4] <= 4'd5) && (LOAD_SEC[3:0] <= 4'd9);
    assign inc_ok  = (INC_SEC[7:4] <= 4'd5) && (INC_SEC[3:0] <= 4'd9);
    assign inc_val = inc_ok ? INC_SEC : 8'h00;
    assign cur_time    = time_q[active_q];
    assign dec_time    = bcd_dec(cur_time);
    assign next_active = (active_q == PW'(N_PLAYERS - 1)) ? '0 : active_q + 1'b1;

    // Edge history runs regardless of CE so no stale edge survives a CE gap.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            select_hist <= 1'b0;
            load_hist   <= 1'b0;
        end else begin
            select_hist <= SELECT;
            load_hist   <= Set_Impulse;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q    <= IDLE;
            time_q     <= {N_PLAYERS{{RESET_MIN, RESET_SEC}}};
            active_q   <= '0;
            flag_q     <= '0;
            presc_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            active_q   <= active_d;
            flag_q     <= flag_d;
            presc_q    <= presc_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        active_d   = active_q;
        flag_d     = flag_q;
        presc_d    = presc_q;
        load_err_d = 1'b0;
        work_time  = cur_time;

        if (CE) begin
            unique case (state_q)
                IDLE: begin
                    if (ld_e) begin
                        if (load_ok) begin
                            time_d   = {N_PLAYERS{{LOAD_MIN, LOAD_SEC}}};
                            flag_d   = '0;
                            active_d = '0;
                            presc_d  = '0;
                        end else begin
                            load_err_d = 1'b1;
                        end
                    end else if (sel_e) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (cur_time == 16'h0000) begin
                        flag_d[active_q] = 1'b1;
                        state_d          = FLAGGED;
                    end else if (STOP) begin
                        state_d = PAUSE;
                    end else if (tick && dec_time == 16'h0000) begin
                        // Flag-fall beats a coincident handover.
                        time_d[active_q] = 16'h0000;
                        flag_d[active_q] = 1'b1;
                        state_d          = FLAGGED;
                        presc_d          = '0;
                    end else begin
                        work_time = tick ? dec_time : cur_time;
                        presc_d   = tick ? '0 : presc_q + 1'b1;
                        if (sel_e) begin
                            work_time = bcd_add_sec(work_time, inc_val);
                            active_d  = next_active;
                            presc_d   = '0;
                        end
                        time_d[active_q] = work_time;
                    end
                end
                PAUSE, FLAGGED: begin
                    if (ld_e) begin
                        if (load_ok) begin
                            time_d   = {N_PLAYERS{{LOAD_MIN, LOAD_SEC}}};
                            flag_d   = '0;
                            active_d = '0;
                            presc_d  = '0;
                            state_d  = IDLE;
                        end else begin
                            load_err_d = 1'b1;
                        end
                    end else if (state_q == PAUSE && !STOP) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign TIME_BCD = time_q;
    assign ACTIVE   = active_q;
    assign FLAG     = flag_q;
    assign RUNNING  = (state_q == RUN);
    assign LOAD_ERR = load_err_q;

endmodule

// File: tb/tb_chess_clock_core_n.sv
// Directed bench for chess_clock_core_n with three players and a four-cycle second.
module tb_chess_clock_core_n;

    localparam int N_PLAYERS = 3;
    localparam int TICK_DIV  = 4;

    logic        CLK = 1'b0;
    logic        CLR, CE, SELECT, STOP, Set_Impulse;
    logic [7:0]  LOAD_MIN, LOAD_SEC, INC_SEC;
    logic [47:0] TIME_BCD;
    logic [1:0]  ACTIVE;
    logic [2:0]  FLAG;
    logic        RUNNING, LOAD_ERR;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [7:0]  min;
        logic [7:0]  sec;
        logic        exp_err;
        logic [15:0] exp_time;
    } load_vec_t;

    typedef struct {
        logic [7:0]  min;
        logic [7:0]  sec;
        logic [15:0] exp_time;
        logic        exp_flag;
    } dec_vec_t;

    load_vec_t load_tab[7];
    dec_vec_t  dec_tab[7];

    chess_clock_core_n #(
        .N_PLAYERS(N_PLAYERS),
        .TICK_DIV (TICK_DIV),
        .RESET_MIN(8'h05),
        .RESET_SEC(8'h00)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .CE         (CE),
        .SELECT     (SELECT),
        .STOP       (STOP),
        .Set_Impulse(Set_Impulse),
        .LOAD_MIN   (LOAD_MIN),
        .LOAD_SEC   (LOAD_SEC),
        .INC_SEC    (INC_SEC),
        .TIME_BCD   (TIME_BCD),
        .ACTIVE     (ACTIVE),
        .FLAG       (FLAG),
        .RUNNING    (RUNNING),
        .LOAD_ERR   (LOAD_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Pause (if running), then strobe a load; err reports LOAD_ERR the cycle after.
    task automatic applyStimulus(input logic [7:0] min, input logic [7:0] sec, output logic err);
        STOP = 1'b1;
        step(1);
        LOAD_MIN    = min;
        LOAD_SEC    = sec;
        Set_Impulse = 1'b1;
        step(1);
        err         = LOAD_ERR;
        Set_Impulse = 1'b0;
        STOP        = 1'b0;
        step(1);
    endtask

    task automatic startRun();
        SELECT = 1'b1;
        step(1);
        SELECT = 1'b0;
    endtask

    task automatic pulseSelect();
        SELECT = 1'b1;
        step(1);
        SELECT = 1'b0;
        step(1);
    endtask

    initial begin
        logic err;

        load_tab[0] = '{8'h12, 8'h34, 1'b0, 16'h1234};
        load_tab[1] = '{8'h1A, 8'h00, 1'b1, 16'h1234};
        load_tab[2] = '{8'h00, 8'h60, 1'b1, 16'h1234};
        load_tab[3] = '{8'h00, 8'h5A, 1'b1, 16'h1234};
        load_tab[4] = '{8'hA0, 8'h00, 1'b1, 16'h1234};
        load_tab[5] = '{8'h00, 8'h59, 1'b0, 16'h0059};
        load_tab[6] = '{8'h99, 8'h59, 1'b0, 16'h9959};

        dec_tab[0] = '{8'h05, 8'h00, 16'h0459, 1'b0};
        dec_tab[1] = '{8'h10, 8'h00, 16'h0959, 1'b0};
        dec_tab[2] = '{8'h01, 8'h00, 16'h0059, 1'b0};
        dec_tab[3] = '{8'h00, 8'h10, 16'h0009, 1'b0};
        dec_tab[4] = '{8'h99, 8'h59, 16'h9958, 1'b0};
        dec_tab[5] = '{8'h20, 8'h30, 16'h2029, 1'b0};
        dec_tab[6] = '{8'h00, 8'h01, 16'h0000, 1'b1};

        CLR = 1'b1; CE = 1'b1; SELECT = 1'b0; STOP = 1'b0; Set_Impulse = 1'b0;
        LOAD_MIN = 8'h00; LOAD_SEC = 8'h00; INC_SEC = 8'h00;
        step(2);
        checkOutput("reset_time", TIME_BCD, 48'h0500_0500_0500);
        checkOutput("reset_active", 48'(ACTIVE), 48'd0);
        checkOutput("reset_flag", 48'(FLAG), 48'd0);
        checkOutput("reset_running", 48'(RUNNING), 48'd0);
        checkOutput("reset_load_err", 48'(LOAD_ERR), 48'd0);
        CLR = 1'b0;
        step(1);

        // First start: two ticks of player 0
        startRun();
        step(8);
        checkOutput("start_p0", 48'(TIME_BCD[15:0]), 48'h0458);
        checkOutput("start_running", 48'(RUNNING), 48'd1);

        // Handover with increment and wrap of ACTIVE
        INC_SEC = 8'h05;
        pulseSelect();
        checkOutput("hand_p0", 48'(TIME_BCD[15:0]), 48'h0503);
        checkOutput("hand_active1", 48'(ACTIVE), 48'd1);
        pulseSelect();
        checkOutput("hand_active2", 48'(ACTIVE), 48'd2);
        pulseSelect();
        checkOutput("hand_wrap", 48'(ACTIVE), 48'd0);
        checkOutput("hand_times", TIME_BCD, 48'h0505_0505_0503);

        // Flag-fall
        INC_SEC = 8'h00;
        applyStimulus(8'h00, 8'h02, err);
        checkOutput("flag_load_err", 48'(err), 48'd0);
        startRun();
        step(8);
        checkOutput("flag_time", TIME_BCD, 48'h0002_0002_0000);
        checkOutput("flag_flag", 48'(FLAG), 48'b001);
        checkOutput("flag_running", 48'(RUNNING), 48'd0);
        pulseSelect();
        checkOutput("flag_frozen_time", TIME_BCD, 48'h0002_0002_0000);
        checkOutput("flag_frozen_active", 48'(ACTIVE), 48'd0);
        checkOutput("flag_frozen_flag", 48'(FLAG), 48'b001);
        applyStimulus(8'h03, 8'h00, err);
        checkOutput("flag_clear", 48'(FLAG), 48'd0);
        checkOutput("flag_reload", TIME_BCD, 48'h0300_0300_0300);

        // Tick and SELECT together reaching 00:00: flag-fall wins
        applyStimulus(8'h00, 8'h01, err);
        startRun();
        step(3);
        SELECT = 1'b1;
        step(1);
        SELECT = 1'b0;
        checkOutput("coinc_flag", 48'(FLAG), 48'b001);
        checkOutput("coinc_active", 48'(ACTIVE), 48'd0);
        checkOutput("coinc_p0", 48'(TIME_BCD[15:0]), 48'h0000);

        // Tick and SELECT together: decrement then increment then handover
        INC_SEC = 8'h03;
        applyStimulus(8'h00, 8'h10, err);
        startRun();
        step(3);
        SELECT = 1'b1;
        step(1);
        SELECT = 1'b0;
        checkOutput("coinc2_p0", 48'(TIME_BCD[15:0]), 48'h0012);
        checkOutput("coinc2_active", 48'(ACTIVE), 48'd1);
        checkOutput("coinc2_flag", 48'(FLAG), 48'd0);

        // Pause mid-second, rejected load, resume with prescaler continuing
        step(2);
        STOP = 1'b1;
        step(1);
        checkOutput("pause_running", 48'(RUNNING), 48'd0);
        step(10);
        checkOutput("pause_hold", 48'(TIME_BCD[31:16]), 48'h0010);
        LOAD_MIN = 8'h00;
        LOAD_SEC = 8'h60;
        Set_Impulse = 1'b1;
        step(1);
        checkOutput("bad_load_err", 48'(LOAD_ERR), 48'd1);
        Set_Impulse = 1'b0;
        step(1);
        checkOutput("bad_load_err_pulse", 48'(LOAD_ERR), 48'd0);
        checkOutput("bad_load_times", TIME_BCD, 48'h0010_0010_0012);
        checkOutput("bad_load_paused", 48'(RUNNING), 48'd0);
        STOP = 1'b0;
        step(1);
        checkOutput("resume_running", 48'(RUNNING), 48'd1);
        step(1);
        checkOutput("resume_no_tick", 48'(TIME_BCD[31:16]), 48'h0010);
        step(1);
        checkOutput("resume_tick", TIME_BCD, 48'h0010_0009_0012);

        // Saturation at 99:59
        INC_SEC = 8'h30;
        applyStimulus(8'h99, 8'h59, err);
        startRun();
        step(4);
        checkOutput("sat_tick", 48'(TIME_BCD[15:0]), 48'h9958);
        pulseSelect();
        checkOutput("sat_p0", 48'(TIME_BCD[15:0]), 48'h9959);
        checkOutput("sat_active", 48'(ACTIVE), 48'd1);

        // CE low for 10 cycles with a SELECT edge that must not act later
        step(1);
        CE = 1'b0;
        step(3);
        SELECT = 1'b1;
        step(7);
        checkOutput("ce_hold_times", TIME_BCD, 48'h9959_9959_9959);
        checkOutput("ce_hold_active", 48'(ACTIVE), 48'd1);
        CE = 1'b1;
        step(1);
        checkOutput("ce_return_active", 48'(ACTIVE), 48'd1);
        checkOutput("ce_return_p1", 48'(TIME_BCD[31:16]), 48'h9959);
        step(1);
        SELECT = 1'b0;
        checkOutput("ce_tick_p1", 48'(TIME_BCD[31:16]), 48'h9958);
        checkOutput("ce_tick_active", 48'(ACTIVE), 48'd1);

        // Load validity table
        INC_SEC = 8'h00;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(load_tab[i].min, load_tab[i].sec, err);
            checkOutput($sformatf("load%0d_err", i), 48'(err), 48'(load_tab[i].exp_err));
            checkOutput($sformatf("load%0d_err_gone", i), 48'(LOAD_ERR), 48'd0);
            checkOutput($sformatf("load%0d_time", i), TIME_BCD,
                        {load_tab[i].exp_time, load_tab[i].exp_time, load_tab[i].exp_time});
            checkOutput($sformatf("load%0d_flag", i), 48'(FLAG), 48'd0);
        end

        // BCD decrement table: one tick from each preset
        for (int i = 0; i < 7; i++) begin
            applyStimulus(dec_tab[i].min, dec_tab[i].sec, err);
            startRun();
            step(4);
            checkOutput($sformatf("dec%0d_p0", i), 48'(TIME_BCD[15:0]), 48'(dec_tab[i].exp_time));
            checkOutput($sformatf("dec%0d_p1", i), 48'(TIME_BCD[31:16]),
                        48'({dec_tab[i].min, dec_tab[i].sec}));
            checkOutput($sformatf("dec%0d_flag", i), 48'(FLAG), 48'({2'b00, dec_tab[i].exp_flag}));
            checkOutput($sformatf("dec%0d_running", i), 48'(RUNNING), 48'(!dec_tab[i].exp_flag));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
